// File: rtl/reset_sequencer.sv
// Purpose : staggered release of N_CH active-low resets after power-on, a software request or a watchdog expiry.
// Latency : channel k releases HOLD_CYCLES + k*STAGE_GAP edges after the trigger edge; all outputs are registered.
// Backpressure: requests arriving while a sequence runs are dropped (no queuing); sw_ack reports every acceptance.
// Optional watchdog auto re-sequencing is built when RST_SEQ_WDOG_EN is defined.
module reset_sequencer #(
  parameter int N_CH        = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGE_GAP   = 2,
  parameter int CNT_W       = 8
`ifdef RST_SEQ_WDOG_EN
  , parameter int WDOG_CYCLES = 64
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sw_req,
  input  logic [N_CH-1:0]  sw_mask,
`ifdef RST_SEQ_WDOG_EN
  input  logic             wdog_kick,
  output logic             wdog_fired,
`endif
  output logic [N_CH-1:0]  rst_n_out,
  output logic             busy,
  output logic             sw_ack,
  output logic             done,
  output logic [CNT_W-1:0] seq_count
);

  // Slot index must be able to address every channel, including the single-channel case.
  localparam int SLOT_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_CH - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = 32'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t            state;
  logic [31:0]       cnt;
  logic [SLOT_W-1:0] slot;
  logic [N_CH-1:0]   act_mask;

  logic slot_due;
  logic wdog_expire;
  logic sw_accept;

  // Slot timing: slot 0 waits the hold time, every later slot waits one stage gap.
  always_comb begin
    slot_due = 1'b0;
    if (state == ST_HOLD) begin
      slot_due = (cnt == HOLD_LAST);
    end else if (state == ST_RELEASE) begin
      slot_due = (cnt == GAP_LAST);
    end
  end

`ifdef RST_SEQ_WDOG_EN
  // Watchdog counter width: at least 16 bits, wider only if the timeout needs it.
  localparam int WDOG_W = ($clog2(WDOG_CYCLES + 1) > 16) ? $clog2(WDOG_CYCLES + 1) : 16;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt;

  // Expiry only counts in RUN and only when the same edge carries no kick.
  always_comb begin
    wdog_expire = (state == ST_RUN) && !wdog_kick && (wdog_cnt == WDOG_LAST);
  end

  // Watchdog counter: held at zero while a sequence runs, cleared by kicks, sticky fired flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt   <= '0;
      wdog_fired <= 1'b0;
    end else if (state != ST_RUN || wdog_kick) begin
      wdog_cnt <= '0;
    end else if (wdog_expire) begin
      wdog_cnt   <= '0;
      wdog_fired <= 1'b1;
    end else begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end
`else
  // Without the watchdog nothing but software can restart a sequence.
  always_comb begin
    wdog_expire = 1'b0;
  end
`endif

  // A software request is honoured only in RUN, with a non-empty mask, and loses to a watchdog expiry.
  always_comb begin
    sw_accept = (state == ST_RUN) && sw_req && (|sw_mask) && !wdog_expire;
  end

  // Sequencer FSM: hold, staggered release, then run until the next trigger.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_HOLD;
      cnt       <= '0;
      slot      <= '0;
      act_mask  <= '1;
      rst_n_out <= '0;
      busy      <= 1'b1;
      sw_ack    <= 1'b0;
      done      <= 1'b0;
      seq_count <= '0;
    end else begin
      sw_ack <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_HOLD, ST_RELEASE: begin
          if (slot_due) begin
            cnt <= '0;
            // Unselected channels keep their level but still use up their slot.
            if (act_mask[slot]) begin
              rst_n_out[slot] <= 1'b1;
            end
            if (slot == LAST_SLOT) begin
              state     <= ST_RUN;
              slot      <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              seq_count <= seq_count + 1'b1;
            end else begin
              state <= ST_RELEASE;
              slot  <= slot + 1'b1;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_RUN: begin
          if (wdog_expire) begin
            // Watchdog restart behaves like a full power-on sequence, without an ack.
            state     <= ST_HOLD;
            cnt       <= '0;
            slot      <= '0;
            act_mask  <= '1;
            rst_n_out <= '0;
            busy      <= 1'b1;
          end else if (sw_accept) begin
            state     <= ST_HOLD;
            cnt       <= '0;
            slot      <= '0;
            act_mask  <= sw_mask;
            rst_n_out <= rst_n_out & ~sw_mask;
            busy      <= 1'b1;
            sw_ack    <= 1'b1;
          end
        end
        default: begin
          state <= ST_HOLD;
          cnt   <= '0;
          slot  <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios with literal expectations, then random traffic,
// all outputs compared every cycle against an edge-arithmetic schedule model.
module tb_reset_sequencer;

  localparam int N_CH     = 2;
  localparam int HOLD     = 4;
  localparam int GAP      = 2;
  localparam int CNT_W    = 2;
  localparam int WDOG     = 8;
  localparam int LAST_OFF = HOLD + (N_CH - 1) * GAP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset   = 1'b1;
  logic             sw_req  = 1'b0;
  logic [N_CH-1:0]  sw_mask = '0;
  logic [N_CH-1:0]  rst_n_out;
  logic             busy;
  logic             sw_ack;
  logic             done;
  logic [CNT_W-1:0] seq_count;
`ifdef RST_SEQ_WDOG_EN
  logic             wdog_kick = 1'b0;
  logic             wdog_fired;
`endif

  reset_sequencer #(
    .N_CH(N_CH), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .CNT_W(CNT_W)
`ifdef RST_SEQ_WDOG_EN
    , .WDOG_CYCLES(WDOG)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_req(sw_req),
    .sw_mask(sw_mask),
`ifdef RST_SEQ_WDOG_EN
    .wdog_kick(wdog_kick),
    .wdog_fired(wdog_fired),
`endif
    .rst_n_out(rst_n_out),
    .busy(busy),
    .sw_ack(sw_ack),
    .done(done),
    .seq_count(seq_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Outputs are derived from the trigger edge number: channel k is high once
  // (edge - trigger) >= HOLD + k*GAP if it was selected, else it keeps its prior level.
  int              e       = 0;
  int              trig    = 0;
  int              clr     = 0;
  int              m_seq   = 0;
  bit              m_valid = 0;
  bit              m_active = 0;
  bit              m_ack   = 0;
  bit              m_done  = 0;
  bit              m_wf    = 0;
  bit              m_fire  = 0;
  bit              kick_v  = 0;
  logic [N_CH-1:0] amask   = '1;
  logic [N_CH-1:0] base    = '0;
  logic [N_CH-1:0] m_rst   = '0;

  function automatic logic [N_CH-1:0] sched(input int now);
    logic [N_CH-1:0] r;
    for (int k = 0; k < N_CH; k++) begin
      r[k] = amask[k] ? (now >= trig + HOLD + k * GAP) : base[k];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    e++;
    m_ack  = 0;
    m_done = 0;
    m_fire = 0;
`ifdef RST_SEQ_WDOG_EN
    kick_v = wdog_kick;
`else
    kick_v = 0;
`endif
    if (reset) begin
      m_valid  = 1;
      m_active = 1;
      trig     = e;
      amask    = '1;
      base     = '0;
      m_seq    = 0;
      m_wf     = 0;
    end else if (m_valid) begin
      if (m_active) begin
        if (e - trig == LAST_OFF) begin
          m_active = 0;
          m_done   = 1;
          m_seq    = (m_seq + 1) % (1 << CNT_W);
          clr      = e;
        end
      end else begin
`ifdef RST_SEQ_WDOG_EN
        m_fire = !kick_v && (e - clr == WDOG);
`endif
        if (kick_v) clr = e;
        if (m_fire) begin
          m_active = 1;
          trig     = e;
          amask    = '1;
          base     = '0;
          m_wf     = 1;
        end else if (sw_req && sw_mask != '0) begin
          base     = m_rst & ~sw_mask;
          amask    = sw_mask;
          trig     = e;
          m_active = 1;
          m_ack    = 1;
        end
      end
    end
    m_rst = sched(e);
  end

  // Cycle-by-cycle comparison against the model.
  always @(posedge clk) begin
    #2;
    if (m_valid) begin
      chk("m_rst_n_out", 32'(rst_n_out), 32'(m_rst));
      chk("m_busy", 32'(busy), 32'(m_active));
      chk("m_sw_ack", 32'(sw_ack), 32'(m_ack));
      chk("m_done", 32'(done), 32'(m_done));
      chk("m_seq_count", 32'(seq_count), 32'(m_seq));
`ifdef RST_SEQ_WDOG_EN
      chk("m_wdog_fired", 32'(wdog_fired), 32'(m_wf));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #3;
  endtask

  logic [CNT_W-1:0] t5_exp [4];

  initial begin
    t5_exp = '{2'd2, 2'd3, 2'd0, 2'd1};

    // T1: power-on sequence, E0 is the third reset edge.
    reset = 1'b1;
    step();
    chk("t1_reset_rst", 32'(rst_n_out), 32'h0);
    chk("t1_reset_busy", 32'(busy), 32'h1);
    chk("t1_reset_seq", 32'(seq_count), 32'h0);
    chk("t1_reset_done", 32'(done), 32'h0);
    chk("t1_reset_ack", 32'(sw_ack), 32'h0);
    step();
    step();
    reset = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("t1_rst", 32'(rst_n_out), (j < 4) ? 32'h0 : (j < 6) ? 32'h1 : 32'h3);
      chk("t1_busy", 32'(busy), (j < 6) ? 32'h1 : 32'h0);
      chk("t1_done", 32'(done), (j == 6) ? 32'h1 : 32'h0);
    end
    chk("t1_seq", 32'(seq_count), 32'h1);

    // T2: re-sequence channel 1 only.
    sw_req = 1'b1;
    sw_mask = 2'b10;
    step();
    chk("t2_ack", 32'(sw_ack), 32'h1);
    chk("t2_rst0", 32'(rst_n_out), 32'h1);
    sw_req = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      step();
      chk("t2_rst", 32'(rst_n_out), (j < 6) ? 32'h1 : 32'h3);
      chk("t2_ack_low", 32'(sw_ack), 32'h0);
    end
    chk("t2_done", 32'(done), 32'h1);
    chk("t2_seq", 32'(seq_count), 32'h2);

    // T3: requests during a sequence and with an empty mask are ignored.
    sw_req = 1'b1;
    sw_mask = 2'b01;
    step();
    chk("t3_ack", 32'(sw_ack), 32'h1);
    chk("t3_rst0", 32'(rst_n_out), 32'h2);
    sw_req = 1'b0;
    step();
    sw_req = 1'b1;
    sw_mask = 2'b11;
    step();
    chk("t3_busy_drop_ack", 32'(sw_ack), 32'h0);
    chk("t3_busy_drop_rst", 32'(rst_n_out), 32'h2);
    sw_req = 1'b0;
    step();
    step();
    chk("t3_rst4", 32'(rst_n_out), 32'h3);
    step();
    step();
    chk("t3_done", 32'(done), 32'h1);
    chk("t3_seq", 32'(seq_count), 32'h3);
    sw_req = 1'b1;
    sw_mask = 2'b00;
    step();
    chk("t3_zero_ack", 32'(sw_ack), 32'h0);
    chk("t3_zero_busy", 32'(busy), 32'h0);
    chk("t3_zero_rst", 32'(rst_n_out), 32'h3);
    sw_req = 1'b0;

    // T4: reset pulsed mid power-on sequence restarts the schedule.
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (5) step();
    chk("t4_mid_rst", 32'(rst_n_out), 32'h1);
    reset = 1'b1;
    step();
    chk("t4_rst", 32'(rst_n_out), 32'h0);
    chk("t4_seq", 32'(seq_count), 32'h0);
    chk("t4_busy", 32'(busy), 32'h1);
    reset = 1'b0;
    repeat (4) step();
    chk("t4_rst4", 32'(rst_n_out), 32'h1);
    repeat (2) step();
    chk("t4_rst6", 32'(rst_n_out), 32'h3);
    chk("t4_done", 32'(done), 32'h1);
    chk("t4_seq1", 32'(seq_count), 32'h1);

    // T5: back-to-back software sequences wrap the 2-bit counter.
    for (int i = 0; i < 4; i++) begin
      sw_req = 1'b1;
      sw_mask = N_CH'($urandom_range(1, 3));
      step();
      chk("t5_ack", 32'(sw_ack), 32'h1);
      sw_req = 1'b0;
      repeat (6) step();
      chk("t5_done", 32'(done), 32'h1);
      chk("t5_seq", 32'(seq_count), 32'(t5_exp[i]));
    end

    // Random traffic, checked only by the model.
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      sw_req = ($urandom_range(0, 3) == 0);
      sw_mask = N_CH'($urandom());
`ifdef RST_SEQ_WDOG_EN
      wdog_kick = ($urandom_range(0, 5) == 0);
`endif
      step();
    end
    reset = 1'b0;
    sw_req = 1'b0;

`ifdef RST_SEQ_WDOG_EN
    // T6: watchdog expiry without kicks, then regular kicks keep it quiet.
    wdog_kick = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (13) step();
    chk("t6_pre_fired", 32'(wdog_fired), 32'h0);
    chk("t6_pre_rst", 32'(rst_n_out), 32'h3);
    step();
    chk("t6_fired", 32'(wdog_fired), 32'h1);
    chk("t6_rst", 32'(rst_n_out), 32'h0);
    chk("t6_busy", 32'(busy), 32'h1);
    chk("t6_no_ack", 32'(sw_ack), 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      wdog_kick = (i % 5 == 0);
      step();
    end
    wdog_kick = 1'b0;
    chk("t6_kick_fired", 32'(wdog_fired), 32'h0);
    chk("t6_kick_rst", 32'(rst_n_out), 32'h3);
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
